// File: rtl/result_drain_pkg.sv
// ---------------------------------------------------------------------------
// result_drain_pkg
//   Shared definitions for the results-SRAM drain stage:
//     - default geometry of the results SRAM and the output stream
//     - FSM state encoding shared by the top level
//     - helper used to size the per-row beat counter
// ---------------------------------------------------------------------------
package result_drain_pkg;

  // Default geometry. The top level exposes these as overridable parameters.
  localparam int ADDRESSSIZE_DEF    = 10;
  localparam int PARTIAL_SUM_BW_DEF = 24;
  localparam int MATRIX_SIZE_DEF    = 32;
  localparam int LANES_DEF          = 4;

  // Drain sequencer states. The encoding is fixed so that the state value
  // seen on a waveform or debug bus matches the documented numbering.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STREAM = 3'd3,
    ST_FIN    = 3'd4
  } state_e;

  // Width of a counter that must hold 0 .. beats-1. A single-beat row still
  // gets a 1-bit counter so that no zero-width vector is ever declared.
  function automatic int beat_cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int BEATS_PER_ROW_DEF = MATRIX_SIZE_DEF / LANES_DEF;
  localparam int BEAT_W_DEF        = beat_cnt_width(BEATS_PER_ROW_DEF);

endpackage : result_drain_pkg

// File: rtl/result_drain_row_serializer.sv
// ---------------------------------------------------------------------------
// row_serializer
//   Holds one results-SRAM row and presents it as a sequence of LANES-wide
//   beats. The owning FSM decides when a new row is loaded and when the
//   current beat has been accepted; this block only stores and selects.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (clears buffer and counter)
//   load       in   capture row_in into the buffer and restart at beat 0
//   row_in     in   full SRAM row, element i at [i*PSUM_BW +: PSUM_BW]
//   advance    in   current beat was accepted downstream; step to the next
//   beat_data  out  current beat, lane j at [j*PSUM_BW +: PSUM_BW]
//   row_last   out  current beat is the final beat of the row
// ---------------------------------------------------------------------------
module row_serializer
  import result_drain_pkg::*;
#(
  parameter int PSUM_BW     = PARTIAL_SUM_BW_DEF,
  parameter int MATRIX_SIZE = MATRIX_SIZE_DEF,
  parameter int LANES       = LANES_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load,
  input  logic [PSUM_BW*MATRIX_SIZE-1:0] row_in,
  input  logic                           advance,
  output logic [PSUM_BW*LANES-1:0]       beat_data,
  output logic                           row_last
);

  localparam int BEATS     = MATRIX_SIZE / LANES;
  localparam int BEAT_W    = beat_cnt_width(BEATS);
  localparam int BEAT_BITS = PSUM_BW * LANES;

  // Viewing the row as an array of beats makes lane selection a plain index:
  // beat k covers elements k*LANES .. k*LANES+LANES-1 in their original order.
  logic [BEATS-1:0][BEAT_BITS-1:0] row_d, row_q;
  logic [BEAT_W-1:0]               beat_d, beat_q;

  // NOTE: every combinational output gets a default before any branch;
  // a path that leaves a variable unassigned would infer a latch.
  always_comb begin
    row_d  = row_q;
    beat_d = beat_q;
    if (load) begin
      row_d  = row_in;
      beat_d = '0;
    end else if (advance) begin
      beat_d = row_last ? '0 : beat_q + BEAT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the row buffer is a register bank, not an SRAM macro, so it is
      // cleared on reset; a stale row must never leak onto out_data.
      row_q  <= '0;
      beat_q <= '0;
    end else begin
      row_q  <= row_d;
      beat_q <= beat_d;
    end
  end

  assign beat_data = row_q[beat_q];
  assign row_last  = (beat_q == BEAT_W'(BEATS - 1));

endmodule : row_serializer

// File: rtl/result_drain.sv
// ---------------------------------------------------------------------------
// result_drain
//   Read-out stage for the results SRAM written by the systolic array.
//   A start command latches a base row address and a row count; the block
//   then fetches each row (1-cycle synchronous SRAM read), and streams it out
//   as MATRIX_SIZE/LANES beats on a valid/ready interface. The row address
//   wraps modulo 2^ADDRESSSIZE. done pulses once, the cycle after the final
//   beat is accepted (or the cycle after start when row_count is zero).
//
// Ports
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset; aborts any transfer
//   start         in   one-cycle command, honoured only while idle
//   base_addr     in   first row address, sampled on an accepted start
//   row_count     in   rows to drain (0 .. 2^ADDRESSSIZE), sampled on start
//   rd_en         out  results-SRAM read strobe
//   rd_addr       out  results-SRAM read address (0 when not reading)
//   rd_data       in   SRAM row, valid the cycle after rd_en
//   out_valid     out  beat valid
//   out_ready     in   downstream accept
//   out_data      out  beat payload, LANES elements
//   out_row_last  out  final beat of the current row
//   out_last      out  final beat of the final row
//   busy          out  high from accepted start through the done cycle;
//                      the top-level address mux selects rd_addr while high
//   done          out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module result_drain
  import result_drain_pkg::*;
#(
  parameter int ADDRESSSIZE    = ADDRESSSIZE_DEF,
  parameter int PARTIAL_SUM_BW = PARTIAL_SUM_BW_DEF,
  parameter int MATRIX_SIZE    = MATRIX_SIZE_DEF,
  parameter int LANES          = LANES_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [ADDRESSSIZE-1:0]              base_addr,
  input  logic [ADDRESSSIZE:0]                row_count,
  output logic                                rd_en,
  output logic [ADDRESSSIZE-1:0]              rd_addr,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] rd_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [PARTIAL_SUM_BW*LANES-1:0]     out_data,
  output logic                                out_row_last,
  output logic                                out_last,
  output logic                                busy,
  output logic                                done
);

  localparam int ROWS_W = ADDRESSSIZE + 1;

  state_e                 state_d, state_q;
  logic [ADDRESSSIZE-1:0] addr_d, addr_q;    // address of the row in flight
  logic [ROWS_W-1:0]      rows_d, rows_q;    // rows left, including current

  logic                            ser_load;
  logic                            ser_advance;
  logic [PARTIAL_SUM_BW*LANES-1:0] ser_data;
  logic                            ser_row_last;
  logic                            last_row;

  row_serializer #(
    .PSUM_BW     (PARTIAL_SUM_BW),
    .MATRIX_SIZE (MATRIX_SIZE),
    .LANES       (LANES)
  ) u_row_serializer (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .row_in    (rd_data),
    .advance   (ser_advance),
    .beat_data (ser_data),
    .row_last  (ser_row_last)
  );

  // The row currently streaming is the final one when only it remains.
  assign last_row = (rows_q == ROWS_W'(1));

  // Next-state and control decode. All strobes are decoded from the
  // registered state, so every output is glitch-free relative to the edge
  // and returns to 0 in the cycle after a reset.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rows_d      = rows_q;
    ser_load    = 1'b0;
    ser_advance = 1'b0;
    rd_en       = 1'b0;
    out_valid   = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          rows_d  = row_count;
          // An empty range still reports completion through FIN.
          state_d = (row_count == '0) ? ST_FIN : ST_FETCH;
        end
      end

      ST_FETCH: begin
        rd_en   = 1'b1;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // rd_data is valid this cycle (read issued in FETCH).
        ser_load = 1'b1;
        state_d  = ST_STREAM;
      end

      ST_STREAM: begin
        out_valid = 1'b1;
        if (out_ready) begin
          ser_advance = 1'b1;
          if (ser_row_last) begin
            rows_d  = rows_q - ROWS_W'(1);
            // Natural overflow of the address register gives the wrap.
            addr_d  = addr_q + ADDRESSSIZE'(1);
            state_d = last_row ? ST_FIN : ST_FETCH;
          end
        end
      end

      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rows_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rows_q  <= rows_d;
    end
  end

  // Output qualification: payload and framing flags are forced to 0 outside
  // STREAM so the bus is quiet between rows. Inside STREAM they come straight
  // from the buffer, which only changes on a handshake or a load, so they
  // hold steady under backpressure.
  assign busy         = (state_q != ST_IDLE);
  assign rd_addr      = rd_en ? addr_q : '0;
  assign out_data     = out_valid ? ser_data : '0;
  assign out_row_last = out_valid & ser_row_last;
  assign out_last     = out_row_last & last_row;

endmodule : result_drain

// File: tb/tb_result_drain.sv
// ---------------------------------------------------------------------------
// tb_result_drain
//   Scoreboard bench for result_drain. A behavioural SRAM holds random rows;
//   each accepted start pushes the expected beat sequence (derived from the
//   element/lane numbering rules) into a queue, and a monitor pops and
//   compares on every handshake. Timing, address and framing properties are
//   checked from logs kept by the monitor.
// ---------------------------------------------------------------------------
module tb_result_drain;

  localparam int AW    = 10;
  localparam int BW    = 24;
  localparam int MS    = 32;
  localparam int LN    = 4;
  localparam int NROWS = 1 << AW;
  localparam int BPR   = MS / LN;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [AW-1:0]      base_addr;
  logic [AW:0]        row_count;
  logic               rd_en;
  logic [AW-1:0]      rd_addr;
  logic [BW*MS-1:0]   rd_data;
  logic               out_valid;
  logic               out_ready;
  logic [BW*LN-1:0]   out_data;
  logic               out_row_last;
  logic               out_last;
  logic               busy;
  logic               done;

  result_drain #(
    .ADDRESSSIZE    (AW),
    .PARTIAL_SUM_BW (BW),
    .MATRIX_SIZE    (MS),
    .LANES          (LN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .row_count    (row_count),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_row_last (out_row_last),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Results SRAM: 1-cycle synchronous read.
  logic [BW*MS-1:0] mem [NROWS];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // ---------------- checking infrastructure ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [BW*LN-1:0] data;
    logic             row_last;
    logic             last;
  } beat_t;

  beat_t exp_q[$];

  // Monitor logs, cleared per job.
  int  rdaddr_q[$];
  int  valid_rise_q[$];
  int  hs_cyc_q[$];
  int  rowlast_hs_q[$];
  int  hs_cnt, done_cnt, done_cyc, first_rden_cyc, busy_cnt;
  bit  done_seen;

  // Ready generator: 0 = always ready, 1 = 1,0,0 pattern, 2 = random.
  int mode = 0;
  int ph   = 0;
  always @(posedge clk) begin
    #1;
    case (mode)
      0:       out_ready = 1'b1;
      1:       begin out_ready = (ph % 3 == 0); ph++; end
      default: out_ready = ($urandom_range(3) != 0);
    endcase
  end

  // Monitor
  logic             prev_valid = 1'b0;
  logic             prev_stall = 1'b0;
  logic [BW*LN-1:0] prev_data;
  logic             prev_rl, prev_l;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (rd_en) begin
        rdaddr_q.push_back(int'(rd_addr));
        if (first_rden_cyc < 0) first_rden_cyc = cyc;
      end
      if (out_valid && !prev_valid) valid_rise_q.push_back(cyc);
      if (prev_stall) begin
        check("stall_valid_hold", out_valid, 1);
        check("stall_data_hold", out_data, prev_data);
        check("stall_flags_hold", {out_row_last, out_last}, {prev_rl, prev_l});
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        hs_cyc_q.push_back(cyc);
        if (out_row_last) rowlast_hs_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", out_data, e.data);
          check("beat_row_last", out_row_last, e.row_last);
          check("beat_last", out_last, e.last);
        end
      end
      if (done) begin
        done_cnt++;
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
      prev_valid = out_valid;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_rl    = out_row_last;
      prev_l     = out_last;
    end
  end

  // ---------------- reference model ----------------
  // Beat k of a row carries elements k*LN .. k*LN+LN-1, lane j = element k*LN+j.
  task automatic push_expected(input int base, input int cnt);
    for (int r = 0; r < cnt; r++) begin
      int a;
      a = (base + r) % NROWS;
      for (int k = 0; k < BPR; k++) begin
        beat_t b;
        for (int j = 0; j < LN; j++)
          b.data[j*BW +: BW] = mem[a][(k*LN + j)*BW +: BW];
        b.row_last = (k == BPR - 1);
        b.last     = (k == BPR - 1) && (r == cnt - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic clear_logs();
    rdaddr_q.delete();
    valid_rise_q.delete();
    hs_cyc_q.delete();
    rowlast_hs_q.delete();
    hs_cnt = 0; done_cnt = 0; done_cyc = -1; first_rden_cyc = -1;
    busy_cnt = 0; done_seen = 1'b0;
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 one cycle
  // later. Returns the start cycle T.
  task automatic issue_start(input int base, input int cnt, output int t);
    clear_logs();
    push_expected(base, cnt);
    t         = cyc;
    start     = 1'b1;
    base_addr = AW'(base);
    row_count = (AW+1)'(cnt);
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = AW'($urandom);
    row_count = (AW+1)'($urandom);
  endtask

  // Waits for done (bounded), checks busy drops the next cycle and the
  // scoreboard drained, then realigns to posedge+1.
  task automatic finish_job();
    for (int i = 0; i < 3000 && !done_seen; i++) begin
      @(negedge clk); #1;
    end
    check("done_timeout", done_seen, 1);
    @(negedge clk); #1;
    check("busy_after_done", busy, 0);
    check("done_count", done_cnt, 1);
    check("scoreboard_empty", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic check_addrs(input int base, input int cnt);
    check("rd_addr_count", rdaddr_q.size(), cnt);
    for (int r = 0; r < cnt && r < rdaddr_q.size(); r++)
      check("rd_addr_seq", rdaddr_q[r], (base + r) % NROWS);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_en"},     rd_en, 0);
    check({tag, "_rd_addr"},   rd_addr, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"},  out_data, 0);
    check({tag, "_row_last"},  out_row_last, 0);
    check({tag, "_last"},      out_last, 0);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_done"},      done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int t;
    rst = 1'b1; start = 1'b0; base_addr = '0; row_count = '0; out_ready = 1'b0;
    clear_logs();
    for (int a = 0; a < NROWS; a++)
      for (int w = 0; w < BW*MS/32; w++)
        mem[a][w*32 +: 32] = $urandom;
    for (int i = 0; i < MS; i++) mem[5][i*BW +: BW] = BW'(i + 1);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1. Single row, always ready
    mode = 0;
    issue_start(5, 1, t);
    finish_job();
    check("t1_rd_en_cycle", first_rden_cyc, t + 1);
    check_addrs(5, 1);
    check("t1_first_valid", (valid_rise_q.size() > 0) ? valid_rise_q[0] : -1, t + 3);
    check("t1_handshakes", hs_cnt, BPR);
    check("t1_last_hs", (rowlast_hs_q.size() > 0) ? rowlast_hs_q[0] : -1, t + 10);
    check("t1_done_cycle", done_cyc, t + 11);

    // 2. Backpressure, 1,0,0 ready pattern
    mode = 1; ph = 0;
    issue_start(5, 1, t);
    finish_job();
    check("t2_handshakes", hs_cnt, BPR);
    check("t2_done_after_last", done_cyc,
          (hs_cyc_q.size() > 0) ? hs_cyc_q[hs_cyc_q.size()-1] + 1 : -1);

    // 3. Multi-row with address wrap
    mode = 0;
    issue_start(1023, 3, t);
    finish_job();
    check_addrs(1023, 3);
    check("t3_handshakes", hs_cnt, 3 * BPR);
    check("t3_row_last_count", rowlast_hs_q.size(), 3);
    if (valid_rise_q.size() == 3 && rowlast_hs_q.size() == 3) begin
      check("t3_gap_row1", valid_rise_q[1], rowlast_hs_q[0] + 3);
      check("t3_gap_row2", valid_rise_q[2], rowlast_hs_q[1] + 3);
    end else begin
      check("t3_row_starts", valid_rise_q.size(), 3);
    end

    // 4. Empty range
    issue_start(77, 0, t);
    finish_job();
    check("t4_no_rd_en", rdaddr_q.size(), 0);
    check("t4_no_beats", valid_rise_q.size(), 0);
    check("t4_done_cycle", done_cyc, t + 1);
    check("t4_busy_cycles", busy_cnt, 1);

    // 5. Start while busy is ignored
    issue_start(10, 2, t);
    for (int i = 0; i < 200 && hs_cnt < 3; i++) begin
      @(negedge clk); #1;
    end
    check("t5_reached_stream", out_valid, 1);
    start = 1'b1; base_addr = AW'(20); row_count = (AW+1)'(1);
    @(posedge clk); #1;
    start = 1'b0;
    finish_job();
    check_addrs(10, 2);
    check("t5_handshakes", hs_cnt, 2 * BPR);

    // 6. Reset during row 2, beat 3
    issue_start(40, 3, t);
    for (int i = 0; i < 200 && hs_cnt < BPR + 3; i++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    check("t6_mid_row2", out_valid, 1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("t6_no_done", done_cnt, 0);
    check("t6_idle_after", busy, 0);
    issue_start(0, 1, t);
    finish_job();
    check("t6_first_valid", (valid_rise_q.size() > 0) ? valid_rise_q[0] : -1, t + 3);
    check("t6_done_cycle", done_cyc, t + 11);

    // 7. Random ranges with random backpressure
    mode = 2;
    for (int n = 0; n < 6; n++) begin
      int b, c;
      b = $urandom_range(NROWS - 1);
      c = $urandom_range(4, 1);
      issue_start(b, c, t);
      finish_job();
      check_addrs(b, c);
      check("rand_handshakes", hs_cnt, c * BPR);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_result_drain
